kronos_lsu_seq: RTL and testbench
=================================

Name: kronos_lsu_seq

Overview:
Parametrised next-generation load/store sequencer for the Kronos write-back stage. It accepts one RV32 load or store per start pulse and drives the single-port data bus. Boundary-crossing accesses are either split into two word accesses or rejected as misaligned, selected by parameter. An optional ack timeout reports a bus error instead of hanging the pipeline. Results return to the WB register-write mux as load_data/load_rd/load_write.

Parameters:
MISALIGNED_TRAP, 0, 0: split boundary-crossing accesses into two word accesses; 1: never issue misaligned accesses, complete without bus traffic
ACK_TIMEOUT, 0, max cycles data_req may wait for data_ack; 0 disables timeout
TIMEOUT_W, 8, width of the wait counter; ACK_TIMEOUT must be < 2**TIMEOUT_W

Ports:
clk  in  1  clock
rstz  in  1  asynchronous active-low reset
start  in  1  begin access; sampled only in IDLE
ld  in  1  load request
st  in  1  store request
addr  in  32  byte address
store_data  in  32  store data, LSB-justified
data_size  in  2  0 byte, 1 half, 2 word, 3 treated as word
data_uns  in  1  zero-extend loads
rd  in  5  load destination register
done  out  1  one-cycle completion pulse
load_data  out  32  extended load result
load_rd  out  5  destination of load_data
load_write  out  1  one-cycle register write strobe
addr_misaligned  out  1  combinational: (ld|st) and addr not naturally aligned for data_size
bus_error  out  1  valid with done: access aborted by timeout
data_addr  out  32  word-aligned bus address
data_rd_data  in  32  bus read data
data_wr_data  out  32  bus write data
data_wr_mask  out  4  byte write enables
data_wr_en  out  1  write qualifier
data_req  out  1  bus request, held until ack
data_ack  in  1  bus acknowledge

Behaviour:
- States: IDLE, ACC0, ACC1, FIN. All outputs except addr_misaligned are registered. Reset value of every output is 0, and the FSM resets to IDLE. An asserted rstz drops data_req immediately; an in-flight access is discarded and nothing is written.
- IDLE + start + (ld|st): latch rd, size, uns, offset=addr[1:0], ld/st. Compute cross = offset+bytes(size) > 4.
  - If MISALIGNED_TRAP=1 and addr_misaligned: go to FIN, no bus access, load_write=0.
  - Otherwise go to ACC0 with data_addr={addr[31:2],2'b00}, data_req=1, data_wr_en=st.
- start with neither ld nor st is ignored.
- Store lane placement:
  - ACC0: mask=(smask<<offset)[3:0], data=store_data<<(8*offset)
  - ACC1: mask=(smask<<offset)[7:4], data=store_data>>(8*(4-offset))
  - smask is 1, 3 or F.
- ACC0 + data_ack:
  - Capture data_rd_data as w0.
  - If cross (split mode only): go to ACC1 with data_addr+4; data_req stays high with no gap cycle.
  - Otherwise go to FIN.
- ACC1 + data_ack: capture w1, go to FIN.
- FIN (one cycle):
  - done=1.
  - For loads without error: load_write=1, load_rd=rd, load_data=extend(({w1,w0}>>8*offset)[size]).
  - data_req=0. Return to IDLE.
- Latency, zero-wait bus with ack in the first request cycle: aligned start at T gives done at T+2; split gives done at T+3; trapped misaligned gives done at T+1. Each wait cycle adds one cycle.
- Timeout, when ACK_TIMEOUT>0:
  - The counter clears on entering each ACC state and increments each cycle data_req=1 and data_ack=0.
  - When the counter reaches ACK_TIMEOUT, go to FIN with bus_error=1, load_write=0, data_req=0.
  - A timed-out second half of a split store leaves the first half written; there is no rollback.
- data_ack in the same cycle as the timeout threshold wins over the timeout.
- data_ack outside ACC0/ACC1 is ignored. The address wraps modulo 2**32 on the ACC1 increment.
- The WB stage holds its pipe ready low until done; start while not IDLE is ignored.

Decomposition:
- kronos_types package gains:
  - enum lsu_state_e
  - constants SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - trap causes LOAD_ACCESS_FAULT (5) and STORE_ACCESS_FAULT (7), which WB raises on bus_error
- One sub-module: kronos_lsu_align. It is purely combinational and handles load byte-lane extraction plus sign/zero extension from {w1,w0}, offset, size and uns.

Test Plan:
- Aligned LW addr=0x100, rd=5, bus returns 0xDEADBEEF with zero wait -> one req at 0x100, done at T+2, load_write with load_data=0xDEADBEEF, load_rd=5.
- LB addr=0x203, byte 0x80, uns=0 -> load_data=0xFFFFFF80; with uns=1 -> 0x00000080.
- MISALIGNED_TRAP=0, SW addr=0x302, data 0xAABBCCDD:
  - req 0x300, mask 0xC, data 0xCCDD0000
  - req 0x304, mask 0x3, data 0x0000AABB
  - done at T+3
- MISALIGNED_TRAP=1, LH addr=0x401 -> addr_misaligned=1, no data_req, done at T+1, load_write=0.
- ACK_TIMEOUT=4, LW with ack never returned -> data_req high 4 cycles then low, done with bus_error=1, no load_write. Repeat with ack on the 4th cycle -> normal load, bus_error=0.
- rstz asserted while in ACC1 waiting -> data_req=0 immediately, all outputs 0, next start after reset completes normally.

Source files
------------

// File: rtl/kronos_lsu_seq_pkg.sv
// Shared types and helpers for the Kronos load/store sequencer.
//   lsu_state_e          : sequencer FSM states
//   SIZE_BYTE/HALF/WORD  : data_size encodings (3 behaves as word)
//   LOAD/STORE_ACCESS_FAULT : trap causes WB raises when bus_error is reported
//   size_mask / size_bytes / is_misaligned : size decode helpers
package kronos_lsu_seq_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_ACC0 = 2'd1,
    LSU_ACC1 = 2'd2,
    LSU_FIN  = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [3:0] LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] STORE_ACCESS_FAULT = 4'd7;

  // Byte-enable pattern of an access before lane placement.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    unique case (size)
      SIZE_BYTE: return 4'h1;
      SIZE_HALF: return 4'h3;
      default:   return 4'hF;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    unique case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    unique case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      default:   return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/kronos_lsu_align.sv
// Load alignment: picks the addressed bytes out of the two captured bus
// words and sign/zero-extends them to 32 bits. Purely combinational.
//   lane_data : {w1[23:0], w0}; the top byte of w1 can never be addressed
//   offset    : byte offset of the access inside w0
//   size      : data_size encoding
//   uns       : zero-extend when set
//   result    : extended load value
module kronos_lsu_align
  import kronos_lsu_seq_pkg::*;
(
  input  logic [55:0] lane_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    unique case (offset)
      2'd0:    shifted = lane_data[31:0];
      2'd1:    shifted = lane_data[39:8];
      2'd2:    shifted = lane_data[47:16];
      default: shifted = lane_data[55:24];
    endcase

    unique case (size)
      SIZE_BYTE: result = {{24{~uns & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: result = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default:   result = shifted;
    endcase
  end

endmodule

// File: rtl/kronos_lsu_seq.sv
// Kronos load/store sequencer. Takes one load or store per start pulse in
// IDLE and runs it on the single-port data bus, splitting word-boundary
// crossings into two word beats (or trapping them when MISALIGNED_TRAP=1).
// Ports:
//   clk, rstz                 : clock, asynchronous active-low reset
//   start, ld, st, addr, store_data, data_size, data_uns, rd : request
//   done, bus_error           : one-cycle completion pulse and its error flag
//   load_data, load_rd, load_write : register write-back
//   addr_misaligned           : combinational alignment check of the request
//   data_*                    : data bus
// Bus handshake: data_req rises with data_addr/data_wr_* valid and all of them
// hold steady until data_ack; a beat completes on the clock edge where
// data_req and data_ack are both high. A split access re-requests the next
// word on that same edge, so there is no idle cycle between beats.
module kronos_lsu_seq
  import kronos_lsu_seq_pkg::*;
#(
  parameter bit          MISALIGNED_TRAP = 1'b0,
  parameter int unsigned ACK_TIMEOUT     = 0,
  parameter int unsigned TIMEOUT_W       = 8
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic        start,
  input  logic        ld,
  input  logic        st,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [1:0]  data_size,
  input  logic        data_uns,
  input  logic [4:0]  rd,
  output logic        done,
  output logic [31:0] load_data,
  output logic [4:0]  load_rd,
  output logic        load_write,
  output logic        addr_misaligned,
  output logic        bus_error,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd_data,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_wr_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic        data_ack
);

  lsu_state_e state, state_d;

  // Request fields latched on acceptance.
  logic [4:0]  rd_q;
  logic [1:0]  size_q, off_q;
  logic        uns_q, ld_q, cross_q;
  logic [31:0] sd_q, w0_q, w0_d;

  logic [TIMEOUT_W-1:0] cnt, cnt_d, cnt_inc;

  logic        done_d, load_write_d, bus_error_d, data_wr_en_d, data_req_d;
  logic [31:0] load_data_d, data_addr_d, data_wr_data_d;
  logic [4:0]  load_rd_d;
  logic [3:0]  data_wr_mask_d;

  logic        accept, trap, cross_in, timeout_hit, fin, fin_err;
  logic [7:0]  mask8_in, mask8_q;
  logic [31:0] align_data;

  assign addr_misaligned = (ld | st) & is_misaligned(addr[1:0], data_size);

  assign accept   = (state == LSU_IDLE) && start && (ld || st);
  assign trap     = MISALIGNED_TRAP && addr_misaligned;
  assign cross_in = ({2'b00, addr[1:0]} + {1'b0, size_bytes(data_size)}) > 4'd4;

  // Byte enables over the two words touched; [3:0] first beat, [7:4] second.
  assign mask8_in = {4'b0000, size_mask(data_size)} << addr[1:0];
  assign mask8_q  = {4'b0000, size_mask(size_q)} << off_q;

  assign cnt_inc     = cnt + TIMEOUT_W'(1);
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_inc == TIMEOUT_W'(ACK_TIMEOUT));

  // The final beat's data is still on the bus when the result is formed, so
  // the live read data stands in for whichever word was not yet captured.
  kronos_lsu_align u_align (
    .lane_data ({data_rd_data[23:0], (state == LSU_ACC0) ? data_rd_data : w0_q}),
    .offset    (off_q),
    .size      (size_q),
    .uns       (uns_q),
    .result    (align_data)
  );

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state <= LSU_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    w0_d           = w0_q;
    fin            = 1'b0;
    fin_err        = 1'b0;
    done_d         = 1'b0;
    load_write_d   = 1'b0;
    bus_error_d    = 1'b0;
    load_data_d    = load_data;
    load_rd_d      = load_rd;
    data_addr_d    = data_addr;
    data_wr_data_d = data_wr_data;
    data_wr_mask_d = data_wr_mask;
    data_wr_en_d   = data_wr_en;
    data_req_d     = data_req;

    unique case (state)
      LSU_IDLE: begin
        if (accept) begin
          if (trap) begin
            state_d = LSU_FIN;
            done_d  = 1'b1;
          end else begin
            state_d        = LSU_ACC0;
            cnt_d          = '0;
            data_addr_d    = {addr[31:2], 2'b00};
            data_req_d     = 1'b1;
            data_wr_en_d   = st;
            data_wr_mask_d = st ? mask8_in[3:0] : 4'h0;
            data_wr_data_d = store_data << {addr[1:0], 3'b000};
          end
        end
      end
      LSU_ACC0, LSU_ACC1: begin
        if (data_ack) begin
          if (state == LSU_ACC0) w0_d = data_rd_data;
          if (state == LSU_ACC0 && cross_q) begin
            state_d        = LSU_ACC1;
            cnt_d          = '0;
            data_addr_d    = data_addr + 32'd4;
            data_wr_mask_d = data_wr_en ? mask8_q[7:4] : 4'h0;
            // Second beat carries the bytes that spilled past the word end.
            data_wr_data_d = sd_q >> (6'd32 - {1'b0, off_q, 3'b000});
          end else begin
            fin = 1'b1;
          end
        end else if (timeout_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LSU_FIN: state_d = LSU_IDLE;
    endcase

    if (fin) begin
      state_d        = LSU_FIN;
      done_d         = 1'b1;
      bus_error_d    = fin_err;
      data_req_d     = 1'b0;
      data_wr_en_d   = 1'b0;
      data_wr_mask_d = 4'h0;
      if (ld_q && !fin_err) begin
        load_write_d = 1'b1;
        load_rd_d    = rd_q;
        load_data_d  = align_data;
      end
    end
  end

  // A request with both ld and st set is handled as a store.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rd_q    <= '0;
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      ld_q    <= 1'b0;
      cross_q <= 1'b0;
      sd_q    <= '0;
    end else if (accept) begin
      rd_q    <= rd;
      size_q  <= data_size;
      off_q   <= addr[1:0];
      uns_q   <= data_uns;
      ld_q    <= ld & ~st;
      cross_q <= cross_in;
      sd_q    <= store_data;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      cnt          <= '0;
      w0_q         <= '0;
      done         <= 1'b0;
      load_write   <= 1'b0;
      bus_error    <= 1'b0;
      load_data    <= '0;
      load_rd      <= '0;
      data_addr    <= '0;
      data_wr_data <= '0;
      data_wr_mask <= '0;
      data_wr_en   <= 1'b0;
      data_req     <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      w0_q         <= w0_d;
      done         <= done_d;
      load_write   <= load_write_d;
      bus_error    <= bus_error_d;
      load_data    <= load_data_d;
      load_rd      <= load_rd_d;
      data_addr    <= data_addr_d;
      data_wr_data <= data_wr_data_d;
      data_wr_mask <= data_wr_mask_d;
      data_wr_en   <= data_wr_en_d;
      data_req     <= data_req_d;
    end
  end

endmodule

// File: tb/tb_kronos_lsu_seq.sv
// Bench for kronos_lsu_seq. Two instances: dut_a splits boundary crossings
// and times out after 4 cycles; dut_b traps misaligned accesses. A byte-array
// bus memory answers whichever instance is selected; a separate byte-array
// reference memory predicts load results and store effects.
module tb_kronos_lsu_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstz = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        start = 1'b0, ld = 1'b0, st = 1'b0, data_uns = 1'b0;
  logic [31:0] addr = '0, store_data = '0;
  logic [1:0]  data_size = '0;
  logic [4:0]  rd = '0;
  logic        sel = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rd_data = '0;

  logic        a_done, a_lw, a_mis, a_be, a_we, a_req;
  logic [31:0] a_ld, a_daddr, a_wdata;
  logic [4:0]  a_lrd;
  logic [3:0]  a_mask;
  logic        b_done, b_lw, b_mis, b_be, b_we, b_req;
  logic [31:0] b_ld, b_daddr, b_wdata;
  logic [4:0]  b_lrd;
  logic [3:0]  b_mask;

  kronos_lsu_seq #(.MISALIGNED_TRAP(1'b0), .ACK_TIMEOUT(4), .TIMEOUT_W(8)) dut_a (
    .clk(clk), .rstz(rstz), .start(start & ~sel), .ld(ld), .st(st), .addr(addr),
    .store_data(store_data), .data_size(data_size), .data_uns(data_uns), .rd(rd),
    .done(a_done), .load_data(a_ld), .load_rd(a_lrd), .load_write(a_lw),
    .addr_misaligned(a_mis), .bus_error(a_be), .data_addr(a_daddr),
    .data_rd_data(rd_data), .data_wr_data(a_wdata), .data_wr_mask(a_mask),
    .data_wr_en(a_we), .data_req(a_req), .data_ack(ack & ~sel)
  );

  kronos_lsu_seq #(.MISALIGNED_TRAP(1'b1), .ACK_TIMEOUT(0), .TIMEOUT_W(8)) dut_b (
    .clk(clk), .rstz(rstz), .start(start & sel), .ld(ld), .st(st), .addr(addr),
    .store_data(store_data), .data_size(data_size), .data_uns(data_uns), .rd(rd),
    .done(b_done), .load_data(b_ld), .load_rd(b_lrd), .load_write(b_lw),
    .addr_misaligned(b_mis), .bus_error(b_be), .data_addr(b_daddr),
    .data_rd_data(rd_data), .data_wr_data(b_wdata), .data_wr_mask(b_mask),
    .data_wr_en(b_we), .data_req(b_req), .data_ack(ack & sel)
  );

  logic        m_done, m_lw, m_mis, m_be, m_we, m_req;
  logic [31:0] m_ld, m_daddr, m_wdata;
  logic [4:0]  m_lrd;
  logic [3:0]  m_mask;
  assign m_done  = sel ? b_done  : a_done;
  assign m_lw    = sel ? b_lw    : a_lw;
  assign m_mis   = sel ? b_mis   : a_mis;
  assign m_be    = sel ? b_be    : a_be;
  assign m_we    = sel ? b_we    : a_we;
  assign m_req   = sel ? b_req   : a_req;
  assign m_ld    = sel ? b_ld    : a_ld;
  assign m_daddr = sel ? b_daddr : a_daddr;
  assign m_wdata = sel ? b_wdata : a_wdata;
  assign m_lrd   = sel ? b_lrd   : a_lrd;
  assign m_mask  = sel ? b_mask  : a_mask;

  // ---------------- memories, scoreboard, counters ----------------
  logic [7:0]  bus_mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] exp_q [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_mask [$];
  logic [31:0] log_data [$];
  int passed = 0;
  int total  = 0;
  int beats = 0, wait_total = 0, ack_limit = 1000000, cur_delay = 0, wcnt = 0;
  bit rand_delay = 1'b0, resp_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---------------- bus responder ----------------
  always @(negedge clk) begin
    if (!rstz) begin
      ack  = 1'b0;
      wcnt = 0;
    end else begin
      if (ack) begin
        ack  = 1'b0;
        wcnt = 0;
      end
      if (m_req && resp_en && beats < ack_limit) begin
        if (wcnt >= cur_delay) begin
          for (int k = 0; k < 4; k++) begin
            rd_data[8*k +: 8] = bus_mem[{m_daddr[9:2], 2'b00} + k];
            if (m_we && m_mask[k]) bus_mem[{m_daddr[9:2], 2'b00} + k] = m_wdata[8*k +: 8];
          end
          log_addr.push_back(m_daddr);
          log_mask.push_back({28'd0, m_mask});
          log_data.push_back(m_wdata);
          ack = 1'b1;
          beats++;
          wait_total += wcnt;
          if (rand_delay) cur_delay = $urandom_range(0, 2);
        end else begin
          wcnt++;
        end
      end else if (!m_req) begin
        wcnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] s);
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic model_cross(input logic [31:0] a, input logic [1:0] s);
    return (int'(a % 4) + nbytes(s)) > 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v = '0;
    int n = nbytes(s);
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) & 32'd1023];
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    for (int i = 0; i < nbytes(s); i++) ref_mem[(a + i) & 32'd1023] = d[8*i +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic run_access(input logic i_ld, input logic i_st, input logic [31:0] i_addr,
                            input logic [31:0] i_sd, input logic [1:0] i_size, input logic i_uns,
                            input logic [4:0] i_rd, input int budget,
                            output int lat, output logic got, output int reqc, output logic mis,
                            output logic o_lw, output logic o_be, output logic [31:0] o_ld,
                            output logic [4:0] o_rd);
    @(negedge clk);
    start = 1'b1; ld = i_ld; st = i_st; addr = i_addr; store_data = i_sd;
    data_size = i_size; data_uns = i_uns; rd = i_rd;
    #1 mis = m_mis;
    lat = 0; got = 1'b0; reqc = 0; o_lw = 1'b0; o_be = 1'b0; o_ld = '0; o_rd = '0;
    while (!got && lat < budget) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (m_req) reqc++;
      if (m_done) begin
        got = 1'b1; o_lw = m_lw; o_be = m_be; o_ld = m_ld; o_rd = m_lrd;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int lat, reqc, b0, w0;
    logic got, mis, lw, be, is_ld, uns;
    logic [31:0] ldv, a, sd, exp;
    logic [4:0] lrd, r;
    logic [1:0] sz;

    for (int i = 0; i < 1024; i++) begin
      bus_mem[i] = 8'($urandom_range(0, 255));
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[256] = 8'hEF; bus_mem[257] = 8'hBE; bus_mem[258] = 8'hAD; bus_mem[259] = 8'hDE;
    bus_mem[515] = 8'h80;
    for (int i = 256; i < 260; i++) ref_mem[i] = bus_mem[i];
    ref_mem[515] = 8'h80;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_a_req", {31'd0, a_req}, 32'd0);
    check("rst_a_done", {31'd0, a_done}, 32'd0);
    check("rst_a_lw", {31'd0, a_lw}, 32'd0);
    check("rst_a_daddr", a_daddr, 32'd0);
    check("rst_a_ldata", a_ld, 32'd0);
    check("rst_b_req", {31'd0, b_req}, 32'd0);
    check("rst_b_done", {31'd0, b_done}, 32'd0);
    rstz = 1'b1;

    // aligned LW, zero wait
    b0 = beats;
    run_access(1, 0, 32'h100, 0, 2'd2, 0, 5'd5, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("lw_done", {31'd0, got}, 32'd1);
    check("lw_latency", lat, 32'd2);
    check("lw_write", {31'd0, lw}, 32'd1);
    check("lw_data", ldv, 32'hDEADBEEF);
    check("lw_rd", {27'd0, lrd}, 32'd5);
    check("lw_beats", beats - b0, 32'd1);
    check("lw_req_addr", log_addr[$], 32'h100);

    // LB sign / zero extension
    run_access(1, 0, 32'h203, 0, 2'd0, 0, 5'd7, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("lb_signed", ldv, 32'hFFFFFF80);
    run_access(1, 0, 32'h203, 0, 2'd0, 1, 5'd7, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("lbu_zero", ldv, 32'h00000080);

    // split store
    log_addr.delete(); log_mask.delete(); log_data.delete();
    run_access(0, 1, 32'h302, 32'hAABBCCDD, 2'd2, 0, 5'd0, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    model_store(32'h302, 32'hAABBCCDD, 2'd2);
    check("sw_split_mis", {31'd0, mis}, 32'd1);
    check("sw_split_latency", lat, 32'd3);
    check("sw_split_nbeats", log_addr.size(), 32'd2);
    check("sw_beat0_addr", log_addr[0], 32'h300);
    check("sw_beat0_mask", log_mask[0], 32'hC);
    check("sw_beat0_data", log_data[0], 32'hCCDD0000);
    check("sw_beat1_addr", log_addr[1], 32'h304);
    check("sw_beat1_mask", log_mask[1], 32'h3);
    check("sw_beat1_data", log_data[1], 32'h0000AABB);
    check("sw_split_lw", {31'd0, lw}, 32'd0);

    // address wrap on the second beat, then read it back
    log_addr.delete(); log_mask.delete(); log_data.delete();
    run_access(0, 1, 32'hFFFFFFFE, 32'h11223344, 2'd2, 0, 5'd0, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    model_store(32'hFFFFFFFE, 32'h11223344, 2'd2);
    check("wrap_beat0_addr", log_addr[0], 32'hFFFFFFFC);
    check("wrap_beat0_data", log_data[0], 32'h33440000);
    check("wrap_beat1_addr", log_addr[1], 32'h0);
    check("wrap_beat1_data", log_data[1], 32'h00001122);
    run_access(1, 0, 32'hFFFFFFFE, 0, 2'd2, 0, 5'd9, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("wrap_load", ldv, 32'h11223344);

    // start without ld/st is ignored
    run_access(0, 0, 32'h100, 0, 2'd2, 0, 5'd1, 5, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("nop_no_done", {31'd0, got}, 32'd0);
    check("nop_no_req", reqc, 32'd0);

    // ack timeout
    resp_en = 1'b0;
    run_access(1, 0, 32'h100, 0, 2'd2, 0, 5'd3, 12, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("to_done", {31'd0, got}, 32'd1);
    check("to_req_cycles", reqc, 32'd4);
    check("to_latency", lat, 32'd5);
    check("to_bus_error", {31'd0, be}, 32'd1);
    check("to_no_write", {31'd0, lw}, 32'd0);
    check("to_req_low", {31'd0, m_req}, 32'd0);
    resp_en = 1'b1;
    cur_delay = 3;
    run_access(1, 0, 32'h100, 0, 2'd2, 0, 5'd3, 12, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("ack4_latency", lat, 32'd5);
    check("ack4_bus_error", {31'd0, be}, 32'd0);
    check("ack4_write", {31'd0, lw}, 32'd1);
    check("ack4_data", ldv, 32'hDEADBEEF);
    cur_delay = 0;

    // reset while waiting in the second beat of a split load
    ack_limit = beats + 1;
    @(negedge clk);
    start = 1'b1; ld = 1'b1; st = 1'b0; addr = 32'h306; data_size = 2'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rst_acc1_req", {31'd0, a_req}, 32'd1);
    check("rst_acc1_addr", a_daddr, 32'h308);
    @(negedge clk);
    #2 rstz = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, a_req}, 32'd0);
    check("rst_mid_lw", {31'd0, a_lw}, 32'd0);
    check("rst_mid_done", {31'd0, a_done}, 32'd0);
    check("rst_mid_ldata", a_ld, 32'd0);
    check("rst_mid_daddr", a_daddr, 32'd0);
    check("rst_mid_mask", {28'd0, a_mask}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rstz = 1'b1;
    ack_limit = 1000000;
    run_access(1, 0, 32'h100, 0, 2'd2, 0, 5'd4, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("post_rst_latency", lat, 32'd2);
    check("post_rst_data", ldv, 32'hDEADBEEF);

    // trapping instance
    sel = 1'b1;
    b0 = beats;
    run_access(1, 0, 32'h401, 0, 2'd1, 0, 5'd6, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("trap_mis", {31'd0, mis}, 32'd1);
    check("trap_latency", lat, 32'd1);
    check("trap_no_req", reqc, 32'd0);
    check("trap_no_beats", beats - b0, 32'd0);
    check("trap_no_write", {31'd0, lw}, 32'd0);
    run_access(1, 0, 32'h100, 0, 2'd2, 0, 5'd6, 20, lat, got, reqc, mis, lw, be, ldv, lrd);
    check("trapinst_lw_latency", lat, 32'd2);
    check("trapinst_lw_data", ldv, 32'hDEADBEEF);
    sel = 1'b0;

    // randomized accesses on the splitting instance
    rand_delay = 1'b1;
    cur_delay = $urandom_range(0, 2);
    for (int it = 0; it < 60; it++) begin
      is_ld = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 1019));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      r   = 5'($urandom_range(1, 31));
      sd  = $urandom;
      if (is_ld) exp_q.push_back(model_load(a, sz, uns));
      b0 = beats;
      w0 = wait_total;
      run_access(is_ld, ~is_ld, a, sd, sz, uns, r, 30, lat, got, reqc, mis, lw, be, ldv, lrd);
      if (!is_ld) model_store(a, sd, sz);
      check("rnd_done", {31'd0, got}, 32'd1);
      check("rnd_mis", {31'd0, mis}, {31'd0, model_mis(a, sz)});
      check("rnd_latency", lat, 32'(2 + int'(model_cross(a, sz)) + (wait_total - w0)));
      check("rnd_beats", beats - b0, 32'(1 + int'(model_cross(a, sz))));
      check("rnd_bus_error", {31'd0, be}, 32'd0);
      check("rnd_load_write", {31'd0, lw}, {31'd0, is_ld});
      if (is_ld) begin
        exp = exp_q.pop_front();
        check("rnd_load_data", ldv, exp);
        check("rnd_load_rd", {27'd0, lrd}, {27'd0, r});
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
